// File: rtl/keypad_pkg.sv
// Shared definitions for the 4x4 keypad scanner: state encoding, matrix size, row classifier.
package keypad_pkg;

    localparam int unsigned NUM_COLS = 4;
    localparam int unsigned NUM_ROWS = 4;
    localparam int unsigned COL_W    = 2;
    localparam int unsigned ROW_W    = 2;

    typedef enum logic [1:0] {
        SCAN     = 2'd0,
        DEBOUNCE = 2'd1,
        HELD     = 2'd2
    } state_t;

    // Result of looking at one row sample: single is set only when exactly one row is low.
    typedef struct packed {
        logic             single;
        logic [ROW_W-1:0] row;
    } row_class_t;

    // Classify a pulled-up row sample; chords (two or more lows) read as "nothing pressed".
    function automatic row_class_t classify_rows(input logic [NUM_ROWS-1:0] rows);
        row_class_t  res;
        int unsigned zeros;
        res.single = 1'b0;
        res.row    = '0;
        zeros      = 0;
        for (int i = 0; i < NUM_ROWS; i++) begin
            if (!rows[i]) begin
                zeros   = zeros + 1;
                res.row = ROW_W'(i);
            end
        end
        res.single = (zeros == 1);
        return res;
    endfunction

endpackage

// File: rtl/keypad_matrix_scanner_sync.sv
// Two-flop synchronizer for asynchronous level inputs; resets to all ones (idle pulled-up lines).
module sync_2ff #(
    parameter int unsigned WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q
);

    logic [WIDTH-1:0] r_meta;
    logic [WIDTH-1:0] r_sync;

    // Two-stage capture to resolve metastability on the raw pins.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_meta <= '1;
            r_sync <= '1;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;

endmodule

// File: rtl/keypad_matrix_scanner.sv
// 4x4 keypad scanner: walks active-low columns, debounces press and release,
// and reports each accepted press as a one-cycle key_valid plus a held level.
module keypad_matrix_scanner
    import keypad_pkg::*;
#(
    parameter int unsigned SCAN_DIV       = 2500,
    parameter int unsigned DEBOUNCE_SCANS = 3
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NUM_ROWS-1:0] keyboard_row,
    output logic [NUM_COLS-1:0] keyboard_col,
    output logic [3:0]          key_code,
    output logic                key_valid,
    output logic                key_held
);

    localparam int unsigned        PRESC_W    = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
    localparam int unsigned        CNT_W      = 4;
    localparam logic [PRESC_W-1:0] PRESC_MAX  = PRESC_W'(SCAN_DIV - 1);
    localparam logic [CNT_W-1:0]   DEB_TARGET = CNT_W'(DEBOUNCE_SCANS);

    logic [PRESC_W-1:0]  r_presc;
    state_t              r_state;
    logic [COL_W-1:0]    r_col_idx;
    logic [NUM_COLS-1:0] r_col;
    logic [ROW_W-1:0]    r_cand_row;
    logic [CNT_W-1:0]    r_cnt;
    logic [3:0]          r_key_code;
    logic                r_key_valid;
    logic                r_key_held;

    logic [NUM_ROWS-1:0] w_row_s;
    logic                w_tick;
    row_class_t          w_cls;
    logic                w_match;
    logic [CNT_W-1:0]    w_cnt_inc;
    logic [COL_W-1:0]    w_col_next;
    logic [NUM_COLS-1:0] w_col_drive_next;

    sync_2ff #(
        .WIDTH (NUM_ROWS)
    ) u_row_sync (
        .clk (clk),
        .rst (rst),
        .i_d (keyboard_row),
        .o_q (w_row_s)
    );

    assign w_tick           = (r_presc == PRESC_MAX);
    assign w_cls            = classify_rows(w_row_s);
    assign w_match          = w_cls.single && (w_cls.row == r_cand_row);
    assign w_cnt_inc        = CNT_W'(r_cnt + CNT_W'(1));
    assign w_col_next       = COL_W'(r_col_idx + COL_W'(1));
    assign w_col_drive_next = ~(NUM_COLS'(1) << w_col_next);

    // Free-running scan-tick prescaler.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_presc <= '0;
        end else if (w_tick) begin
            r_presc <= '0;
        end else begin
            r_presc <= PRESC_W'(r_presc + PRESC_W'(1));
        end
    end

    // Scan / debounce / held state machine; all decisions are taken on scan ticks only.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= SCAN;
            r_col_idx   <= '0;
            r_col       <= 4'b1110;
            r_cand_row  <= '0;
            r_cnt       <= '0;
            r_key_code  <= '0;
            r_key_valid <= 1'b0;
            r_key_held  <= 1'b0;
        end else begin
            r_key_valid <= 1'b0;
            if (w_tick) begin
                case (r_state)
                    SCAN: begin
                        if (w_cls.single) begin
                            r_cand_row <= w_cls.row;
                            if (DEBOUNCE_SCANS == 1) begin
                                r_key_code  <= {w_cls.row, r_col_idx};
                                r_key_valid <= 1'b1;
                                r_key_held  <= 1'b1;
                                r_cnt       <= '0;
                                r_state     <= HELD;
                            end else begin
                                r_cnt   <= CNT_W'(1);
                                r_state <= DEBOUNCE;
                            end
                        end else begin
                            r_col_idx <= w_col_next;
                            r_col     <= w_col_drive_next;
                        end
                    end
                    DEBOUNCE: begin
                        if (w_match) begin
                            if (w_cnt_inc == DEB_TARGET) begin
                                r_key_code  <= {r_cand_row, r_col_idx};
                                r_key_valid <= 1'b1;
                                r_key_held  <= 1'b1;
                                r_cnt       <= '0;
                                r_state     <= HELD;
                            end else begin
                                r_cnt <= w_cnt_inc;
                            end
                        end else begin
                            r_cnt     <= '0;
                            r_state   <= SCAN;
                            r_col_idx <= w_col_next;
                            r_col     <= w_col_drive_next;
                        end
                    end
                    HELD: begin
                        // cnt here counts consecutive "released" samples.
                        if (w_match) begin
                            r_cnt <= '0;
                        end else if (w_cnt_inc == DEB_TARGET) begin
                            r_key_held <= 1'b0;
                            r_cnt      <= '0;
                            r_state    <= SCAN;
                            r_col_idx  <= w_col_next;
                            r_col      <= w_col_drive_next;
                        end else begin
                            r_cnt <= w_cnt_inc;
                        end
                    end
                    default: begin
                        r_cnt   <= '0;
                        r_state <= SCAN;
                    end
                endcase
            end
        end
    end

    assign keyboard_col = r_col;
    assign key_code     = r_key_code;
    assign key_valid    = r_key_valid;
    assign key_held     = r_key_held;

endmodule

// File: tb/tb_keypad_matrix_scanner.sv
// Scoreboard bench for keypad_matrix_scanner with a pin-level 4x4 keypad model.
module tb_keypad_matrix_scanner;

    localparam int unsigned SCAN_DIV       = 4;
    localparam int unsigned DEBOUNCE_SCANS = 3;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] keyboard_row;
    logic [3:0] keyboard_col;
    logic [3:0] key_code;
    logic       key_valid;
    logic       key_held;

    logic [3:0][3:0] keys;          // keys[row][col] = 1 while that key is pressed
    logic [3:0]      exp_q[$];
    logic [3:0]      mon_exp;
    logic [3:0]      col_exp;
    logic            prev_valid = 1'b0;
    int              n_checks = 0;
    int              n_fail   = 0;

    typedef struct {
        int         row;
        int         col;
        logic [3:0] code;
    } vec_t;
    vec_t vecs[3];

    always #5 clk = ~clk;

    keypad_matrix_scanner #(
        .SCAN_DIV       (SCAN_DIV),
        .DEBOUNCE_SCANS (DEBOUNCE_SCANS)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .keyboard_row (keyboard_row),
        .keyboard_col (keyboard_col),
        .key_code     (key_code),
        .key_valid    (key_valid),
        .key_held     (key_held)
    );

    // Keypad model: a pressed key pulls its row low while its column is driven low.
    always_comb begin
        keyboard_row = 4'b1111;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                if (keys[r][c] && keyboard_col[c] == 1'b0) keyboard_row[r] = 1'b0;
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Monitor: every key_valid pops one expected code; pulses must be one cycle wide.
    always @(negedge clk) begin
        if (prev_valid) check("valid_width", 32'(key_valid), 32'd0);
        if (key_valid) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_event: got code %h, expected no event", key_code);
            end else begin
                mon_exp = exp_q.pop_front();
                check("key_code", 32'(key_code), 32'(mon_exp));
                check("held_on_event", 32'(key_held), 32'd1);
            end
        end
        prev_valid = key_valid;
    end

    // Wait for keyboard_col to change to target; returns 1ns after that edge.
    task automatic wait_col(input logic [3:0] target, input string name);
        logic [3:0] prev;
        bit         hit;
        prev = keyboard_col;
        hit  = 1'b0;
        for (int i = 0; i < 64 && !hit; i++) begin
            @(posedge clk); #1;
            if (keyboard_col == target && prev != target) hit = 1'b1;
            prev = keyboard_col;
        end
        if (!hit) begin
            n_checks++;
            n_fail++;
            $display("FAIL %s: column %b not reached, got %b", name, target, keyboard_col);
        end
    endtask

    task automatic wait_valid(input string name);
        bit hit;
        hit = 1'b0;
        for (int i = 0; i < 200 && !hit; i++) begin
            @(posedge clk); #1;
            if (key_valid) hit = 1'b1;
        end
        if (!hit) begin
            n_checks++;
            n_fail++;
            $display("FAIL %s: key_valid timeout, got 0, expected 1", name);
        end
    endtask

    task automatic wait_held_low(input string name);
        bit hit;
        hit = 1'b0;
        for (int i = 0; i < 200 && !hit; i++) begin
            @(posedge clk); #1;
            if (!key_held) hit = 1'b1;
        end
        if (!hit) begin
            n_checks++;
            n_fail++;
            $display("FAIL %s: key_held timeout, got 1, expected 0", name);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{row: 1, col: 3, code: 4'h7};
        vecs[1] = '{row: 0, col: 0, code: 4'h0};
        vecs[2] = '{row: 3, col: 2, code: 4'hE};
        keys = '0;
        rst  = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_col",   32'(keyboard_col), 32'hE);
        check("rst_valid", 32'(key_valid),    32'd0);
        check("rst_held",  32'(key_held),     32'd0);
        check("rst_code",  32'(key_code),     32'd0);
        rst = 1'b0;

        // Idle: one column step every SCAN_DIV clocks, full rotation.
        col_exp = 4'b1110;
        for (int i = 0; i < 4; i++) begin
            repeat (3) @(posedge clk);
            #1;
            check("idle_hold", 32'(keyboard_col), 32'(col_exp));
            @(posedge clk); #1;
            col_exp = {col_exp[2:0], col_exp[3]};
            check("idle_step", 32'(keyboard_col), 32'(col_exp));
        end

        // Stable press at row 2 / col 1.
        exp_q.push_back(4'h9);
        keys[2][1] = 1'b1;
        wait_valid("press_r2c1");
        for (int k = 0; k < 4; k++) begin
            repeat (10) @(posedge clk);
            #1;
            check("held_level", 32'(key_held),     32'd1);
            check("col_frozen", 32'(keyboard_col), 32'hD);
        end

        // Release aligned to a tick: held drops exactly 3 ticks (12 clk) later.
        keys[2][1] = 1'b0;
        repeat (11) @(posedge clk);
        #1;
        check("held_before_release", 32'(key_held), 32'd1);
        @(posedge clk); #1;
        check("held_after_release", 32'(key_held),     32'd0);
        check("resume_col",         32'(keyboard_col), 32'hB);
        check("code_kept",          32'(key_code),     32'h9);

        // Bounce: two good samples then released -> no event.
        wait_col(4'b1101, "bounce_col");
        keys[2][1] = 1'b1;
        repeat (8) @(posedge clk);
        #1;
        check("bounce_frozen", 32'(keyboard_col), 32'hD);
        check("bounce_held",   32'(key_held),     32'd0);
        keys[2][1] = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        check("bounce_resume", 32'(keyboard_col), 32'hB);
        check("bounce_held2",  32'(key_held),     32'd0);

        // Chord on column 0 (rows 0 and 3) is ignored.
        keys[0][0] = 1'b1;
        keys[3][0] = 1'b1;
        for (int k = 0; k < 2; k++) begin
            wait_col(4'b1110, "multi_col");
            repeat (4) @(posedge clk);
            #1;
            check("multi_advance", 32'(keyboard_col), 32'hD);
            check("multi_held",    32'(key_held),     32'd0);
        end
        keys = '0;

        // Directed single keys.
        foreach (vecs[v]) begin
            exp_q.push_back(vecs[v].code);
            keys[vecs[v].row][vecs[v].col] = 1'b1;
            wait_valid("press_vec");
            repeat (20) @(posedge clk);
            #1;
            check("vec_held", 32'(key_held), 32'd1);
            keys = '0;
            wait_held_low("release_vec");
            check("vec_code_kept", 32'(key_code), 32'(vecs[v].code));
        end

        // Reset while HELD, then re-detect the still-pressed key.
        exp_q.push_back(4'h9);
        keys[2][1] = 1'b1;
        wait_valid("press_before_rst");
        repeat (6) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("rst_held_held",  32'(key_held),     32'd0);
        check("rst_held_valid", 32'(key_valid),    32'd0);
        check("rst_held_col",   32'(keyboard_col), 32'hE);
        check("rst_held_code",  32'(key_code),     32'd0);
        exp_q.push_back(4'h9);
        wait_valid("press_after_rst");
        keys = '0;
        wait_held_low("release_after_rst");

        repeat (20) @(posedge clk);
        #1;
        check("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
